// File: rtl/cmd_seq_pkg.sv
// Shared opcodes and FSM state encoding for the command sequencer.
package cmd_seq_pkg;

    localparam logic [7:0] OP_EFB = 8'h80;
    localparam logic [7:0] OP_EF  = 8'h40;

    typedef enum logic [1:0] {
        IDLE,
        TRI,
        EFB,
        EF
    } state_e;

endpackage

// File: rtl/cmd_seq_store.sv
// Triangle record store: one synchronous write port, one combinational read
// port, no reset, so contents survive a sequencer reset.
module cmd_seq_store #(
    parameter int BEAT_W = 240,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BEAT_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [BEAT_W-1:0] rdata
);

    logic [BEAT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Same-cycle write and read of one address returns the pre-write data.
    assign rdata = mem[raddr];

endmodule

// File: rtl/command_sequencer.sv
// Streams stored triangle records, then EFB and EF commands, into the command
// FIFO. Define CMD_SEQ_LOOP_EN to re-run the latched frame after each frame_done.
module command_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int BEAT_W  = 240,
    parameter int BEATS   = 2,
    parameter int NUM_TRI = 4,
    parameter int CNT_W   = 7,
    localparam int AW     = $clog2(NUM_TRI*BEATS),
    localparam int TW     = $clog2(NUM_TRI+1),
    localparam int BW     = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              store_we,
    input  logic [AW-1:0]     store_addr,
    input  logic [BEAT_W-1:0] store_wdata,
    input  logic              start,
    input  logic [TW-1:0]     num_tri,
    input  logic [CNT_W-1:0]  flush_blocks,
    input  logic              cmd_full,
    input  logic              draw_next,
    output logic [BEAT_W-1:0] cmd_wrdata,
    output logic              cmd_push,
    output logic              busy,
    output logic              frame_done
);

    state_e            state;
    logic [BW-1:0]     beat;
    logic [TW-1:0]     rec;
    logic [TW-1:0]     tri_lat;
    logic [CNT_W-1:0]  efb_cnt;
    logic              efb_ready;
`ifdef CMD_SEQ_LOOP_EN
    logic [CNT_W-1:0]  efb_lat;
`endif

    logic [AW-1:0]     rd_addr;
    logic [BEAT_W-1:0] rd_data;
    logic [TW-1:0]     num_tri_clamped;
    logic              last_beat;
    logic              push;
    logic              clear_rdy;

    cmd_seq_store #(
        .BEAT_W (BEAT_W),
        .DEPTH  (NUM_TRI*BEATS)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .waddr (store_addr),
        .wdata (store_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign num_tri_clamped = (num_tri > TW'(NUM_TRI)) ? TW'(NUM_TRI) : num_tri;
    assign rd_addr         = AW'(int'(rec) * BEATS + int'(beat));
    assign last_beat       = (beat == BW'(BEATS-1));
    assign push            = (state != IDLE) && !cmd_full;
    assign clear_rdy       = push && (beat == '0) && (state == EFB || state == EF);
    assign cmd_push        = push;

    always_comb begin
        cmd_wrdata = '0;
        case (state)
            TRI:     cmd_wrdata = rd_data;
            EFB:     if (beat == '0) cmd_wrdata = BEAT_W'(OP_EFB);
            EF:      if (beat == '0) cmd_wrdata = BEAT_W'(OP_EF);
            default: cmd_wrdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= '0;
            rec        <= '0;
            tri_lat    <= '0;
            efb_cnt    <= '0;
            efb_ready  <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef CMD_SEQ_LOOP_EN
            efb_lat    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            // A draw_next in the same cycle as a clear wins.
            efb_ready  <= draw_next | (efb_ready & ~clear_rdy);
            case (state)
                IDLE: begin
                    if (!busy) begin
                        if (start) begin
                            tri_lat <= num_tri_clamped;
                            efb_cnt <= flush_blocks;
                            rec     <= '0;
                            busy    <= 1'b1;
`ifdef CMD_SEQ_LOOP_EN
                            efb_lat <= flush_blocks;
`endif
                        end
                    end else if (rec < tri_lat) begin
                        state <= TRI;
                    end else if (efb_cnt != '0 && efb_ready) begin
                        state <= EFB;
                    end else if (efb_ready) begin
                        state <= EF;
                    end
                end
                default: begin
                    if (push) begin
                        if (state == EFB && beat == '0) efb_cnt <= efb_cnt - CNT_W'(1);
                        if (last_beat) begin
                            beat  <= '0;
                            state <= IDLE;
                            if (state == TRI) rec <= rec + TW'(1);
                            if (state == EF) begin
                                frame_done <= 1'b1;
`ifdef CMD_SEQ_LOOP_EN
                                rec     <= '0;
                                efb_cnt <= efb_lat;
`else
                                busy    <= 1'b0;
`endif
                            end
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule
